// File: rtl/lsu_mem.sv
// lsu_mem: load/store unit in front of a byte-addressed data memory with a
// 24-bit big-endian word view. Handles word loads/stores, byte loads with
// optional sign extension, and byte stores via read-modify-write. One request
// is in flight at a time; completion is a single-cycle response pulse.
module lsu_mem #(
    parameter int MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic        req_sext,
    input  logic [23:0] req_addr,
    input  logic [23:0] req_wdata,
    input  logic [3:0]  req_rd,
    output logic        resp_valid,
    output logic [23:0] resp_data,
    output logic [3:0]  resp_rd,
    output logic        resp_err,
    output logic [23:0] dm_add,
    output logic [23:0] dm_data_in,
    output logic        dm_wen,
    input  logic [23:0] dm_data_out
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR,
        S_RMW_RD,
        S_RMW_WR,
        S_RESP
    } state_t;

    // Highest address at which a full 3-byte word still fits in memory.
    localparam logic [23:0] MAX_ADDR = 24'(MEM_BYTES - 3);

    state_t      r_state;
    state_t      w_next;

    logic        r_byte;
    logic        r_sext;
    logic [23:0] r_addr;
    logic [23:0] r_wdata;
    logic [3:0]  r_rd;
    logic        r_err;
    logic [23:0] r_data;

    logic        w_accept;
    logic        w_rangeErr;
    logic [23:0] w_loadByte;

    assign w_accept   = req_valid && (r_state == S_IDLE);
    assign w_rangeErr = (req_addr > MAX_ADDR);
    assign w_loadByte = r_sext ? {{16{dm_data_out[23]}}, dm_data_out[23:16]}
                               : {16'h0000, dm_data_out[23:16]};

    // State register; reset drops any transaction and forces IDLE at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode plus all outputs, which are pure functions of state.
    always_comb begin
        w_next     = r_state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        resp_data  = 24'h000000;
        resp_rd    = 4'h0;
        resp_err   = 1'b0;
        dm_add     = 24'h000000;
        dm_data_in = 24'h000000;
        dm_wen     = 1'b0;
        case (r_state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_rangeErr) begin
                        w_next = S_RESP;
                    end else if (!req_we) begin
                        w_next = S_RD;
                    end else if (req_byte) begin
                        w_next = S_RMW_RD;
                    end else begin
                        w_next = S_WR;
                    end
                end
            end
            S_RD: begin
                dm_add = r_addr;
                w_next = S_RESP;
            end
            S_WR: begin
                dm_add     = r_addr;
                dm_data_in = r_wdata;
                dm_wen     = 1'b1;
                w_next     = S_RESP;
            end
            S_RMW_RD: begin
                dm_add = r_addr;
                w_next = S_RMW_WR;
            end
            S_RMW_WR: begin
                dm_add     = r_addr;
                dm_data_in = {r_wdata[7:0], r_data[15:0]};
                dm_wen     = 1'b1;
                w_next     = S_RESP;
            end
            S_RESP: begin
                resp_valid = 1'b1;
                resp_data  = r_data;
                resp_rd    = r_rd;
                resp_err   = r_err;
                w_next     = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Request latch and data capture; r_data holds the RMW old word, then the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_byte  <= 1'b0;
            r_sext  <= 1'b0;
            r_addr  <= 24'h000000;
            r_wdata <= 24'h000000;
            r_rd    <= 4'h0;
            r_err   <= 1'b0;
            r_data  <= 24'h000000;
        end else begin
            if (w_accept) begin
                r_byte  <= req_byte;
                r_sext  <= req_sext;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_rd    <= req_rd;
                r_err   <= w_rangeErr;
                r_data  <= 24'h000000;
            end else begin
                case (r_state)
                    S_RD:     r_data <= r_byte ? w_loadByte : dm_data_out;
                    S_RMW_RD: r_data <= dm_data_out;
                    S_RMW_WR: r_data <= 24'h000000;
                    default:  r_data <= r_data;
                endcase
            end
        end
    end

endmodule

// File: doc/lsu_mem.md
LSU_MEM -- requirements
Module: lsu_mem

Interface
REQ-001 Parameter MEM_BYTES, default 256, number of byte locations in the attached data memory.
REQ-002 clk  input  1  rising-edge clock, sole clock.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  request may be accepted this cycle.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_byte  input  1  1 = byte access, 0 = 24-bit word access.
REQ-008 req_sext  input  1  byte load: 1 = sign-extend, 0 = zero-extend.
REQ-009 req_addr  input  24  byte address; word = bytes addr (bits 23:16), addr+1 (15:8), addr+2 (7:0).
REQ-010 req_wdata  input  24  store data; byte store uses bits 7:0.
REQ-011 req_rd  input  4  destination register tag, returned unchanged.
REQ-012 resp_valid  output  1  one-cycle completion pulse.
REQ-013 resp_data  output  24  load result; 0 for stores and errors.
REQ-014 resp_rd  output  4  tag of the completing request.
REQ-015 resp_err  output  1  out-of-range access.
REQ-016 dm_add  output  24  memory address.
REQ-017 dm_data_in  output  24  memory write data.
REQ-018 dm_wen  output  1  memory write enable; memory writes 3 bytes at the rising edge.
REQ-019 dm_data_out  input  24  memory read data, combinational from dm_add.

Function
REQ-020 The block SHALL accept a request on a rising edge where req_valid and req_ready are both 1, and latch all req_* fields at that edge.
REQ-021 req_ready SHALL be 1 only in IDLE; req_* inputs SHALL be ignored in all other states.
REQ-022 States SHALL be IDLE, RD, WR, RMW_RD, RMW_WR, RESP; one cycle each except IDLE.
REQ-023 On acceptance: if addr > MEM_BYTES-3, go to RESP with error; else load -> RD, word store -> WR, byte store -> RMW_RD.
REQ-024 RD SHALL drive dm_add=addr with dm_wen=0 and capture dm_data_out at the cycle-ending edge, then go to RESP.
REQ-025 Word load result SHALL be dm_data_out; byte load result SHALL be bits 23:16 zero- or sign-extended per req_sext.
REQ-026 WR SHALL drive dm_add=addr, dm_data_in=wdata, dm_wen=1, then go to RESP.
REQ-027 RMW_RD SHALL capture dm_data_out; RMW_WR SHALL write {wdata[7:0], captured[15:0]} with dm_wen=1, then go to RESP.
REQ-028 RESP SHALL assert resp_valid=1 with resp_data, resp_rd and resp_err for exactly one cycle, then return to IDLE.
REQ-029 Latency from acceptance edge to resp_valid SHALL be: error 1 cycle; load or word store 2 cycles; byte store 3 cycles.
REQ-030 dm_wen SHALL be 1 only in WR and RMW_WR; error requests SHALL never assert dm_wen.
REQ-031 Outside RD/WR/RMW states, dm_add, dm_data_in and dm_wen SHALL be 0.
REQ-032 A store SHALL be fully committed before its resp_valid, so a load accepted after it returns the new data.
REQ-033 The address range check SHALL use the full 24-bit address with no wrap-around.
REQ-034 resp_valid SHALL have no backpressure; the consumer SHALL sample it in the pulse cycle.

Reset
REQ-035 While rst_n=0 (asynchronously): state=IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_rd=0, resp_err=0, dm_add=0, dm_data_in=0, dm_wen=0.
REQ-036 If reset is asserted mid-transaction, the transaction SHALL be dropped with no response.
REQ-037 If reset is asserted before the edge that ends WR or RMW_WR, dm_wen SHALL fall immediately and the memory SHALL be left unmodified.
REQ-038 After rst_n rises, the first request SHALL be acceptable at the next rising edge.

Verification
REQ-039 Memory bytes 4..6 = 0x0A,0x08,0x02; word load addr 4, tag 3 -> resp_valid 2 cycles after accept, resp_data=0x0A0802, resp_rd=3, resp_err=0.
REQ-040 Byte load addr 4 with sext=1, after byte 4 is set to 0x9C -> resp_data=0xFFFF9C; with sext=0 -> 0x00009C.
REQ-041 Byte store 0x55 to addr 4 over word 0x0A0802 -> dm_wen pulses once 2 cycles after accept; following word load returns 0x550802.
REQ-042 Word load addr 254 with MEM_BYTES=256 -> resp after 1 cycle, resp_err=1, resp_data=0, dm_wen never 1.
REQ-043 Word store 0x123456 to addr 8, with rst_n dropped during WR before the edge -> no resp_valid, bytes 8..10 unchanged, req_ready=1 after reset.
REQ-044 req_valid held high for back-to-back requests -> req_ready low from acceptance until RESP; the second request is accepted on the first edge after RESP.
